ram512x32_wb_ctrl: RTL and testbench
====================================

RAM512X32_WB_CTRL -- requirements
Module: ram512x32_wb_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_VAL, default 32'h0000_0000, the word written to every location by the clear sequencer.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, synchronous active-low reset.
REQ-004 SHALL have port wb_cyc_i, input, 1, Wishbone classic cycle.
REQ-005 SHALL have port wb_stb_i, input, 1, Wishbone strobe.
REQ-006 SHALL have port wb_we_i, input, 1, write enable (1 = write).
REQ-007 SHALL have port wb_sel_i, input, 4, byte selects; bit i selects byte lane [8i+7:8i].
REQ-008 SHALL have port wb_adr_i, input, 11, byte address; bits [10:2] form the word address and bits [1:0] are ignored.
REQ-009 SHALL have port wb_dat_i, input, 32, write data.
REQ-010 SHALL have port wb_dat_o, output, 32, read data.
REQ-011 SHALL have port wb_ack_o, output, 1, transfer acknowledge.
REQ-012 SHALL have port busy_o, output, 1, clear sequencer active.
REQ-013 SHALL have ports ram_cen_o (1), ram_wen_o (1), ram_sel_o (4), ram_adr_o (9), ram_dat_o (32), all outputs, connecting directly to cen_i, wen_i, sel_i, adr_i, dat_i of ram512x32; ram_cen_o high = access enabled.
REQ-014 SHALL have port ram_dat_i, input, 32, from ram512x32 dat_o, valid the cycle after a read access.

Function
REQ-015 SHALL implement FSM states CLEAR, IDLE, ACK.
REQ-016 In IDLE, with wb_cyc_i & wb_stb_i & !busy_o, SHALL accept the request that cycle: drive ram_cen_o=1, ram_adr_o=wb_adr_i[10:2], ram_wen_o=wb_we_i, ram_sel_o=wb_sel_i, ram_dat_o=wb_dat_i combinationally, then go to ACK.
REQ-017 In ACK, SHALL drive wb_ack_o = wb_cyc_i for exactly one cycle, then return to IDLE unconditionally; latency is request cycle + 1.
REQ-018 In ACK, SHALL NOT accept a new request even if wb_stb_i is still high; maximum throughput is one transfer per 2 cycles.
REQ-019 wb_dat_o SHALL equal ram_dat_i during the ACK cycle of a read, and 32'h0 in all other cycles.
REQ-020 While no access or clear is in progress, RAM outputs SHALL be ram_cen_o=0, ram_wen_o=0, ram_sel_o=0, ram_adr_o=0, ram_dat_o=0.
REQ-021 A write with wb_sel_i=4'h0 SHALL perform no byte update and SHALL still be acknowledged.
REQ-022 If wb_cyc_i drops during ACK, wb_ack_o SHALL stay 0; an accepted write is already committed; the FSM still returns to IDLE.
REQ-023 In CLEAR, a 9-bit counter SHALL step 0..511, one location per cycle, driving ram_cen_o=1, ram_wen_o=1, ram_sel_o=4'hF, ram_adr_o=counter, ram_dat_o=CLEAR_VAL; after address 511 the FSM SHALL go to IDLE.
REQ-024 busy_o SHALL be 1 exactly while in CLEAR; Wishbone requests SHALL be held without ack until CLEAR ends and then served in the first IDLE cycle.

Reset
REQ-025 With rst_in=0 at a clock edge, the FSM SHALL enter CLEAR (or IDLE without the macro), clear the counter to 0, and force wb_ack_o=0 and wb_dat_o=0; RAM outputs SHALL take their idle values during reset.
REQ-026 Reset asserted mid-clear or mid-transfer SHALL abort it; a pending ack SHALL be dropped and the clear SHALL restart at address 0.

Configuration
REQ-027 Macro RAM_CLEAR_EN: when defined, the CLEAR state and its counter SHALL be compiled in and run after every reset; when undefined, CLEAR SHALL be absent, reset SHALL enter IDLE, busy_o SHALL be tied to 0, and CLEAR_VAL SHALL be unused.

Verification
REQ-028 RAM_CLEAR_EN defined, release reset -> busy_o=1 for 512 cycles with ram_adr_o stepping 0..511, then busy_o=0; a read of word 0x1FF returns CLEAR_VAL.
REQ-029 Write adr=0x004, dat=32'hDEADBEEF, sel=4'hF; then read adr=0x004 -> wb_ack_o one cycle after each request; read wb_dat_o=32'hDEADBEEF.
REQ-030 Write adr=0x004, dat=32'h11223344, sel=4'b0101 over 32'hDEADBEEF -> subsequent read returns 32'hDE22BE44.
REQ-031 Master holds stb high for back-to-back reads of 0x000 and 0x008 -> acks on cycles 1 and 3 after the first request, never on consecutive cycles.
REQ-032 Request issued while busy_o=1 -> no ack until busy_o falls; ack arrives 1 cycle after the first IDLE cycle.
REQ-033 rst_in=0 at clear address 100 -> after release the clear restarts at ram_adr_o=0 and busy_o stays high for 512 cycles.

Source files
------------

// File: rtl/ram512x32_wb_ctrl.sv
// Wishbone classic slave front-end for a ram512x32 macro: one transfer per two cycles.
// Optional power-on clear sequencer enabled by defining RAM_CLEAR_EN.
module ram512x32_wb_ctrl #(
    parameter logic [31:0] CLEAR_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [10:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        busy_o,
    output logic        ram_cen_o,
    output logic        ram_wen_o,
    output logic [3:0]  ram_sel_o,
    output logic [8:0]  ram_adr_o,
    output logic [31:0] ram_dat_o,
    input  logic [31:0] ram_dat_i
);

    localparam logic [1:0] StIdle = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;
`ifdef RAM_CLEAR_EN
    localparam logic [1:0] StClear = 2'd0;
    localparam logic [1:0] StReset = StClear;
`else
    localparam logic [1:0] StReset = StIdle;
`endif

    logic [1:0] state_q, state_d;
    logic       rd_q, rd_d;
    logic       req;

`ifdef RAM_CLEAR_EN
    logic [8:0] cnt_q, cnt_d;
    assign busy_o = (state_q == StClear);
`else
    logic unused_clear_val;
    assign unused_clear_val = ^CLEAR_VAL;
    assign busy_o = 1'b0;
`endif

    // Byte offset within the word carries no meaning for a 32-bit-only RAM.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    assign req = wb_cyc_i & wb_stb_i & ~busy_o;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
`ifdef RAM_CLEAR_EN
        cnt_d     = cnt_q;
`endif
        wb_ack_o  = 1'b0;
        wb_dat_o  = 32'h0;
        ram_cen_o = 1'b0;
        ram_wen_o = 1'b0;
        ram_sel_o = 4'h0;
        ram_adr_o = 9'h0;
        ram_dat_o = 32'h0;
        case (state_q)
`ifdef RAM_CLEAR_EN
            StClear: begin
                ram_cen_o = 1'b1;
                ram_wen_o = 1'b1;
                ram_sel_o = 4'hF;
                ram_adr_o = cnt_q;
                ram_dat_o = CLEAR_VAL;
                cnt_d     = cnt_q + 9'd1;
                if (cnt_q == 9'd511) begin
                    state_d = StIdle;
                end
            end
`endif
            StIdle: begin
                if (req) begin
                    ram_cen_o = 1'b1;
                    ram_wen_o = wb_we_i;
                    ram_sel_o = wb_sel_i;
                    ram_adr_o = wb_adr_i[10:2];
                    ram_dat_o = wb_dat_i;
                    rd_d      = ~wb_we_i;
                    state_d   = StAck;
                end
            end
            StAck: begin
                // A master that abandoned the cycle gets no ack; a write is already in the RAM.
                wb_ack_o = wb_cyc_i;
                if (rd_q) begin
                    wb_dat_o = ram_dat_i;
                end
                state_d = StIdle;
            end
            default: state_d = StReset;
        endcase
        // Reset is synchronous, so gate outputs to keep the RAM untouched while it is held.
        if (!rst_in) begin
            wb_ack_o  = 1'b0;
            wb_dat_o  = 32'h0;
            ram_cen_o = 1'b0;
            ram_wen_o = 1'b0;
            ram_sel_o = 4'h0;
            ram_adr_o = 9'h0;
            ram_dat_o = 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q <= StReset;
            rd_q    <= 1'b0;
`ifdef RAM_CLEAR_EN
            cnt_q   <= 9'h0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
`ifdef RAM_CLEAR_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram512x32_wb_ctrl.sv
// Self-checking bench for ram512x32_wb_ctrl: behavioural RAM, transaction-level reference
// model compared every cycle, plus directed literal checks; honours RAM_CLEAR_EN.
module tb_ram512x32_wb_ctrl;

    localparam logic [31:0] CV = 32'hA5C3_0F96;
`ifdef RAM_CLEAR_EN
    localparam int CLR_LEN = 512;
`else
    localparam int CLR_LEN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_in;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [10:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_ack, busy;
    logic        ram_cen, ram_wen;
    logic [3:0]  ram_sel;
    logic [8:0]  ram_adr;
    logic [31:0] ram_wdat, ram_rdat;

    always #5 clk = ~clk;

    ram512x32_wb_ctrl #(.CLEAR_VAL(CV)) dut (
        .clk_i     (clk),
        .rst_in    (rst_in),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_we_i   (wb_we),
        .wb_sel_i  (wb_sel),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_dat_w),
        .wb_dat_o  (wb_dat_r),
        .wb_ack_o  (wb_ack),
        .busy_o    (busy),
        .ram_cen_o (ram_cen),
        .ram_wen_o (ram_wen),
        .ram_sel_o (ram_sel),
        .ram_adr_o (ram_adr),
        .ram_dat_o (ram_wdat),
        .ram_dat_i (ram_rdat)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural ram512x32: synchronous, read data valid the cycle after the access.
    logic [31:0] ram_mem [512];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) ram_mem[ram_adr] <= merge(ram_mem[ram_adr], ram_wdat, ram_sel);
            else         ram_q <= ram_mem[ram_adr];
        end
    end
    assign ram_rdat = ram_q;

    // Reference model: clear cycles left, pending ack, and the memory contents it implies.
    int          errors = 0;
    int          checks = 0;
    bit          model_on = 0;
    int          clear_left = 0;
    bit          in_ack = 0, ack_rd = 0, ack_known = 0;
    logic [31:0] ack_data = 32'h0;
    logic [31:0] ref_mem [512];
    bit          ref_known [512];

    logic        obs_ack, obs_busy;
    logic [31:0] obs_dat;
    logic [8:0]  obs_adr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        logic        e_ack, e_busy, e_cen, e_wen, e_dat_ok;
        logic [3:0]  e_sel;
        logic [8:0]  e_adr;
        logic [31:0] e_dat, e_wdat;
        int          w;
        @(negedge clk);
        obs_ack  = wb_ack;
        obs_busy = busy;
        obs_dat  = wb_dat_r;
        obs_adr  = ram_adr;
        if (model_on) begin
            e_ack = 0; e_dat = 0; e_dat_ok = 1; e_busy = (clear_left > 0);
            e_cen = 0; e_wen = 0; e_sel = 0; e_adr = 0; e_wdat = 0;
            if (rst_in) begin
                if (clear_left > 0) begin
                    e_cen = 1; e_wen = 1; e_sel = 4'hF; e_adr = 9'(512 - clear_left); e_wdat = CV;
                end else if (in_ack) begin
                    e_ack = wb_cyc;
                    if (ack_rd) begin
                        e_dat = ack_data;
                        e_dat_ok = ack_known;
                    end
                end else if (wb_cyc && wb_stb) begin
                    e_cen = 1; e_wen = wb_we; e_sel = wb_sel; e_adr = wb_adr[10:2];
                    e_wdat = wb_dat_w;
                end
            end
            check("ack", 32'(wb_ack), 32'(e_ack));
            if (e_dat_ok) check("rdata", wb_dat_r, e_dat);
            check("busy", 32'(busy), 32'(e_busy));
            check("cen", 32'(ram_cen), 32'(e_cen));
            check("wen", 32'(ram_wen), 32'(e_wen));
            check("sel", 32'(ram_sel), 32'(e_sel));
            check("adr", 32'(ram_adr), 32'(e_adr));
            check("wdat", ram_wdat, e_wdat);
        end
        @(posedge clk);
        if (!rst_in) begin
            model_on   = 1;
            clear_left = CLR_LEN;
            in_ack     = 0;
        end else if (clear_left > 0) begin
            ref_mem[512 - clear_left]   = CV;
            ref_known[512 - clear_left] = 1;
            clear_left--;
        end else if (in_ack) begin
            in_ack = 0;
        end else if (wb_cyc && wb_stb) begin
            in_ack = 1;
            ack_rd = !wb_we;
            w = int'(wb_adr[10:2]);
            if (wb_we) begin
                if (wb_sel == 4'hF) begin
                    ref_mem[w] = wb_dat_w;
                    ref_known[w] = 1;
                end else if (ref_known[w]) begin
                    ref_mem[w] = merge(ref_mem[w], wb_dat_w, wb_sel);
                end
            end else begin
                ack_known = ref_known[w];
                ack_data  = ref_mem[w];
            end
        end
        #1;
    endtask

    task automatic idle_bus();
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat_w = 0;
    endtask

    task automatic xfer(input logic we, input logic [10:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output logic [31:0] rd);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_w = dat;
        step();
        check("req_cycle_noack", 32'(obs_ack), 32'h0);
        step();
        check("ack_next_cycle", 32'(obs_ack), 32'h1);
        rd = obs_dat;
        idle_bus();
        step();
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  ackv;
        int          n, busy_cnt;
        for (int i = 0; i < 512; i++) ref_known[i] = 0;
        idle_bus();
        rst_in = 0;
        repeat (3) step();
        check("reset_ack", 32'(obs_ack), 32'h0);
        check("reset_busy", 32'(obs_busy), 32'(CLR_LEN > 0));

        // Read of the top word issued the cycle reset releases: held while clearing.
        rst_in = 1;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_sel = 4'hF; wb_adr = 11'h7FC;
        n = 0; busy_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (obs_busy) busy_cnt++;
            if (obs_ack) break;
            n++;
        end
        idle_bus();
`ifdef RAM_CLEAR_EN
        check("clear_busy_cycles", busy_cnt, 512);
        check("ack_after_clear", n, 513);
        check("read_1ff_clear_val", rd_dummy(obs_dat), CV);
`else
        check("clear_busy_cycles", busy_cnt, 0);
        check("ack_after_req", n, 1);
`endif
        step();

        xfer(1, 11'h004, 4'hF, 32'hDEADBEEF, rd);
        xfer(0, 11'h004, 4'hF, 32'h0, rd);
        check("read_deadbeef", rd, 32'hDEADBEEF);
        xfer(1, 11'h004, 4'b0101, 32'h11223344, rd);
        xfer(0, 11'h004, 4'hF, 32'h0, rd);
        check("read_partial", rd, 32'hDE22BE44);
        xfer(1, 11'h004, 4'h0, 32'hFFFFFFFF, rd);
        xfer(0, 11'h004, 4'hF, 32'h0, rd);
        check("read_sel0_unchanged", rd, 32'hDE22BE44);

        // Back-to-back reads with strobe held high.
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_sel = 4'hF; wb_adr = 11'h000;
        step(); ackv[0] = obs_ack;
        step(); ackv[1] = obs_ack;
        wb_adr = 11'h008;
        step(); ackv[2] = obs_ack;
        step(); ackv[3] = obs_ack;
        idle_bus();
        step();
        check("b2b_ack_pattern", 32'(ackv), 32'h0000000A);

        // Master drops cyc during the ack cycle: no ack, but the write lands.
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_sel = 4'hF; wb_adr = 11'h010;
        wb_dat_w = 32'h0BADF00D;
        step();
        idle_bus();
        step();
        check("drop_cyc_noack", 32'(obs_ack), 32'h0);
        step();
        xfer(0, 11'h010, 4'hF, 32'h0, rd);
        check("drop_cyc_committed", rd, 32'h0BADF00D);

`ifdef RAM_CLEAR_EN
        // Reset in the middle of a clear restarts it from address 0.
        rst_in = 0;
        repeat (2) step();
        rst_in = 1;
        n = 0;
        while (!(obs_busy && obs_adr == 9'd100) && n < 600) begin
            step();
            n++;
        end
        check("reached_clear_100", 32'(obs_adr), 32'd100);
        rst_in = 0;
        step();
        rst_in = 1;
        step();
        check("clear_restart_adr0", 32'(obs_adr), 32'h0);
        busy_cnt = obs_busy ? 1 : 0;
        n = 0;
        while (obs_busy && n < 600) begin
            step();
            if (obs_busy) busy_cnt++;
            n++;
        end
        check("restart_busy_cycles", busy_cnt, 512);
`endif

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [8:0] w;
            rst_in = ($urandom_range(0, 399) != 0);
            wb_cyc = ($urandom_range(0, 7) != 0);
            wb_stb = ($urandom_range(0, 3) != 0);
            wb_we  = $urandom_range(0, 1) == 1;
            wb_sel = 4'($urandom_range(0, 15));
            w = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
            wb_adr = {w, 2'($urandom_range(0, 3))};
            wb_dat_w = $urandom;
            step();
        end
        rst_in = 1;
        idle_bus();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [31:0] rd_dummy(input logic [31:0] v);
        return v;
    endfunction

endmodule
